capture_config_controller: RTL and testbench



---
 rtl/la_cfg_pkg.sv | 20 ++
 rtl/key_event.sv | 54 +++++
 rtl/capture_config_controller.sv | 120 ++++++++++++
 tb/tb_capture_config_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/la_cfg_pkg.sv
// Shared types and widths for the capture configuration controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package la_cfg_pkg;

  localparam int FREQ_W = 29;

  typedef enum logic [1:0] {
    TRIG_NONE    = 2'b00,
    TRIG_RISING  = 2'b01,
    TRIG_FALLING = 2'b10,
    TRIG_EITHER  = 2'b11
  } trig_kind_t;

  typedef enum logic {
    MODE_OR  = 1'b0,
    MODE_AND = 1'b1
  } trig_mode_t;

endpackage

// File: rtl/key_event.sv
// Rising-edge detector for one front-panel key, with optional hold-to-repeat.
// Latency: evt is combinational from key against the registered previous level.
// Backpressure: none; clear drops events and disarms repeat, but the edge register keeps tracking.
module key_event #(
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic clear,
  output logic evt
);

  localparam int CW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

  logic          key_q;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          rep_hit;

  assign rise    = key & ~key_q;
  // armed is only ever set while the key is continuously held, so a repeat
  // can never coincide with a fresh rising edge
  assign rep_hit = REPEAT_EN && armed && key && (cnt == '0);
  assign evt     = ~clear & (rise | rep_hit);

  // Track the key level; count down to the next repeat while held and unlocked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      key_q <= key;
      if (clear || !key || !REPEAT_EN) begin
        armed <= 1'b0;
        cnt   <= '0;
      end else if (rise) begin
        armed <= 1'b1;
        cnt   <= CW'(REPEAT_DELAY - 1);
      end else if (armed) begin
        if (cnt == '0) begin
          cnt <= CW'(REPEAT_PERIOD - 1);
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/capture_config_controller.sv
// Front-panel key events -> sampling rate, per-channel trigger kinds, trigger-combine mode.
// Latency: key rising edge sampled at a clock edge updates all registered outputs at that same edge.
// Backpressure: none; cfg_lock discards all events and disarms auto-repeat.
import la_cfg_pkg::*;

module capture_config_controller #(
  parameter int N_CHANNELS    = 16,
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int N_RATES       = 27,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          faster,
  input  logic                          slower,
  input  logic                          chan_next,
  input  logic                          chan_prev,
  input  logic                          trig_toggle,
  input  logic                          mode_toggle,
  input  logic                          cfg_lock,
  output logic [FREQ_W-1:0]             PRESCALING_FACTOR,
  output logic [FREQ_W-1:0]             SAMPLING_FREQUENCY,
  output trig_kind_t                    TRIGGER_KIND [N_CHANNELS],
  output logic [$clog2(N_CHANNELS)-1:0] CHANNEL_SEL,
  output trig_mode_t                    TRIG_MODE,
  output logic                          CFG_CHANGED
);

  localparam int CH_W = $clog2(N_CHANNELS);
  localparam int RW   = 5;
  localparam logic [CH_W-1:0] CH_MAX   = CH_W'(N_CHANNELS - 1);
  localparam logic [RW-1:0]   RATE_MAX = RW'(N_RATES - 1);

  if (CLK_FREQ_HZ >= (1 << FREQ_W) || N_RATES > 29 || N_RATES < 1 || N_CHANNELS < 2) begin : g_bad_param
    $error("capture_config_controller: illegal parameter combination");
  end

  logic faster_ev, slower_ev, next_ev, prev_ev, trig_ev, mode_ev;

  key_event #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_faster (
    .clk(clk), .rst(rst), .key(faster), .clear(cfg_lock), .evt(faster_ev));
  key_event #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_slower (
    .clk(clk), .rst(rst), .key(slower), .clear(cfg_lock), .evt(slower_ev));
  key_event #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_next (
    .clk(clk), .rst(rst), .key(chan_next), .clear(cfg_lock), .evt(next_ev));
  key_event #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_prev (
    .clk(clk), .rst(rst), .key(chan_prev), .clear(cfg_lock), .evt(prev_ev));
  key_event #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_trig (
    .clk(clk), .rst(rst), .key(trig_toggle), .clear(cfg_lock), .evt(trig_ev));
  key_event #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_mode (
    .clk(clk), .rst(rst), .key(mode_toggle), .clear(cfg_lock), .evt(mode_ev));

  logic [RW-1:0]   rate_idx;
  logic [RW-1:0]   rate_nxt;
  logic [CH_W-1:0] sel_nxt;
  trig_mode_t      mode_nxt;
  trig_kind_t      kind_nxt;
  logic            changed_nxt;

  // Next configuration from this cycle's events; saturated or cancelled moves do not flag a change
  always_comb begin
    rate_nxt    = rate_idx;
    sel_nxt     = CHANNEL_SEL;
    mode_nxt    = TRIG_MODE;
    kind_nxt    = trig_kind_t'(TRIGGER_KIND[CHANNEL_SEL] + 2'd1);
    changed_nxt = 1'b0;

    if (slower_ev && !faster_ev && rate_idx != RATE_MAX) begin
      rate_nxt    = rate_idx + RW'(1);
      changed_nxt = 1'b1;
    end else if (faster_ev && !slower_ev && rate_idx != '0) begin
      rate_nxt    = rate_idx - RW'(1);
      changed_nxt = 1'b1;
    end

    if (next_ev && !prev_ev) begin
      sel_nxt     = (CHANNEL_SEL == CH_MAX) ? '0 : CHANNEL_SEL + CH_W'(1);
      changed_nxt = 1'b1;
    end else if (prev_ev && !next_ev) begin
      sel_nxt     = (CHANNEL_SEL == '0) ? CH_MAX : CHANNEL_SEL - CH_W'(1);
      changed_nxt = 1'b1;
    end

    if (mode_ev) begin
      mode_nxt    = (TRIG_MODE == MODE_OR) ? MODE_AND : MODE_OR;
      changed_nxt = 1'b1;
    end

    if (trig_ev) begin
      changed_nxt = 1'b1;
    end
  end

  // Register configuration; the trigger toggle uses the cursor before any move this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_idx           <= '0;
      PRESCALING_FACTOR  <= FREQ_W'(1);
      SAMPLING_FREQUENCY <= FREQ_W'(CLK_FREQ_HZ);
      CHANNEL_SEL        <= '0;
      TRIG_MODE          <= MODE_OR;
      CFG_CHANGED        <= 1'b0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        TRIGGER_KIND[i] <= TRIG_NONE;
      end
    end else begin
      rate_idx           <= rate_nxt;
      PRESCALING_FACTOR  <= FREQ_W'(1) << rate_nxt;
      SAMPLING_FREQUENCY <= FREQ_W'(CLK_FREQ_HZ) >> rate_nxt;
      CHANNEL_SEL        <= sel_nxt;
      TRIG_MODE          <= mode_nxt;
      CFG_CHANGED        <= changed_nxt;
      if (trig_ev) begin
        TRIGGER_KIND[CHANNEL_SEL] <= kind_nxt;
      end
    end
  end

endmodule

// File: tb/tb_capture_config_controller.sv
// Directed bench for capture_config_controller with short auto-repeat timing.
// Inputs driven 1ns after the rising edge, outputs checked 1ns after the next one.
// Expected values are hand-computed constants or simple arithmetic on loop indices.
import la_cfg_pkg::*;

module tb_capture_config_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        faster = 1'b0, slower = 1'b0, chan_next = 1'b0, chan_prev = 1'b0;
  logic        trig_toggle = 1'b0, mode_toggle = 1'b0, cfg_lock = 1'b0;
  logic [28:0] pf, sf;
  trig_kind_t  kind [16];
  logic [3:0]  sel;
  trig_mode_t  mode;
  logic        chg;

  int n_chk = 0;
  int n_bad = 0;

  capture_config_controller #(
    .N_CHANNELS(16), .CLK_FREQ_HZ(100_000_000), .N_RATES(27),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .rst(rst),
    .faster(faster), .slower(slower), .chan_next(chan_next), .chan_prev(chan_prev),
    .trig_toggle(trig_toggle), .mode_toggle(mode_toggle), .cfg_lock(cfg_lock),
    .PRESCALING_FACTOR(pf), .SAMPLING_FREQUENCY(sf), .TRIGGER_KIND(kind),
    .CHANNEL_SEL(sel), .TRIG_MODE(mode), .CFG_CHANGED(chg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // ---- reset values
    step();
    rst = 1'b0;
    step();
    chk("rst_pf", 32'(pf), 1);
    chk("rst_sf", 32'(sf), 100_000_000);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_chg", 32'(chg), 0);
    for (int c = 0; c < 16; c++) chk("rst_kind", 32'(kind[c]), 0);

    // ---- slower saturation at rate 26, then faster back to rate 0
    for (int i = 0; i < 30; i++) begin
      slower = 1'b1;
      step();
      chk("slow_chg", 32'(chg), (i < 26) ? 1 : 0);
      chk("slow_pf", 32'(pf), 32'(1) << ((i < 26) ? i + 1 : 26));
      slower = 1'b0;
      step();
    end
    chk("slow_pf_end", 32'(pf), 67_108_864);
    chk("slow_sf_end", 32'(sf), 1);
    for (int i = 0; i < 30; i++) begin
      faster = 1'b1;
      step();
      chk("fast_chg", 32'(chg), (i < 26) ? 1 : 0);
      faster = 1'b0;
      step();
    end
    chk("fast_pf_end", 32'(pf), 1);
    chk("fast_sf_end", 32'(sf), 100_000_000);

    // ---- auto-repeat: hold slower 20 cycles from reset
    do_reset();
    slower = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rep_chg", 32'(chg), (i == 0 || i == 8 || i == 12 || i == 16) ? 1 : 0);
    end
    slower = 1'b0;
    step();
    chk("rep_pf", 32'(pf), 16);
    chk("rep_rel_chg", 32'(chg), 0);

    // ---- trigger kind cycling on every channel, cursor wrap
    do_reset();
    for (int ch = 0; ch < 17; ch++) begin
      for (int t = 0; t < 4; t++) begin
        trig_toggle = 1'b1;
        step();
        chk("kind_cyc", 32'(kind[ch % 16]), (t + 1) % 4);
        trig_toggle = 1'b0;
        step();
      end
      chan_next = 1'b1;
      step();
      chk("sel_next", 32'(sel), (ch + 1) % 16);
      chan_next = 1'b0;
      step();
    end
    for (int c = 0; c < 16; c++) chk("kind_all_none", 32'(kind[c]), 0);
    chan_prev = 1'b1;
    step();
    chk("sel_prev", 32'(sel), 0);
    chan_prev = 1'b0;
    step();
    chan_prev = 1'b1;
    step();
    chk("sel_prev_wrap", 32'(sel), 15);
    chan_prev = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chan_next = 1'b1;
      step();
      chan_next = 1'b0;
      step();
    end
    chk("sel_3", 32'(sel), 3);
    trig_toggle = 1'b1;
    step();
    trig_toggle = 1'b0;
    step();
    for (int c = 0; c < 16; c++) chk("kind_ch3", 32'(kind[c]), (c == 3) ? 1 : 0);

    // ---- coincident events
    for (int i = 0; i < 2; i++) begin
      chan_next = 1'b1;
      step();
      chan_next = 1'b0;
      step();
    end
    chk("sel_5", 32'(sel), 5);
    chan_next = 1'b1;
    trig_toggle = 1'b1;
    step();
    chk("co_kind5", 32'(kind[5]), 1);
    chk("co_kind6", 32'(kind[6]), 0);
    chk("co_sel", 32'(sel), 6);
    chk("co_chg", 32'(chg), 1);
    chan_next = 1'b0;
    trig_toggle = 1'b0;
    step();
    slower = 1'b1;
    step();
    chk("pre_pf", 32'(pf), 2);
    slower = 1'b0;
    step();
    faster = 1'b1;
    slower = 1'b1;
    step();
    chk("both_rate_pf", 32'(pf), 2);
    chk("both_rate_chg", 32'(chg), 0);
    faster = 1'b0;
    slower = 1'b0;
    step();
    chan_next = 1'b1;
    chan_prev = 1'b1;
    step();
    chk("both_chan_sel", 32'(sel), 6);
    chk("both_chan_chg", 32'(chg), 0);
    chan_next = 1'b0;
    chan_prev = 1'b0;
    step();

    // ---- config lock
    cfg_lock = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      faster      = (k == 0);
      chan_next   = (k == 1);
      chan_prev   = (k == 2);
      trig_toggle = (k == 3);
      mode_toggle = (k == 4);
      step();
      chk("lock_key_chg", 32'(chg), 0);
      {faster, chan_next, chan_prev, trig_toggle, mode_toggle} = '0;
      step();
    end
    slower = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("lock_hold_chg", 32'(chg), 0);
    end
    cfg_lock = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("unlock_hold_chg", 32'(chg), 0);
    end
    slower = 1'b0;
    step();
    chk("lock_pf", 32'(pf), 2);
    chk("lock_sel", 32'(sel), 6);
    chk("lock_mode", 32'(mode), 0);
    chk("lock_kind6", 32'(kind[6]), 0);

    // ---- asynchronous reset from a non-default configuration
    do_reset();
    for (int i = 0; i < 5; i++) begin
      slower = 1'b1;
      step();
      slower = 1'b0;
      step();
    end
    for (int i = 0; i < 7; i++) begin
      chan_next = 1'b1;
      step();
      chan_next = 1'b0;
      step();
    end
    mode_toggle = 1'b1;
    step();
    mode_toggle = 1'b0;
    trig_toggle = 1'b1;
    step();
    trig_toggle = 1'b0;
    step();
    chk("pre_rst_pf", 32'(pf), 32);
    chk("pre_rst_sf", 32'(sf), 3_125_000);
    chk("pre_rst_sel", 32'(sel), 7);
    chk("pre_rst_mode", 32'(mode), 1);
    chk("pre_rst_kind7", 32'(kind[7]), 1);
    slower = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_pf", 32'(pf), 1);
    chk("arst_sf", 32'(sf), 100_000_000);
    chk("arst_sel", 32'(sel), 0);
    chk("arst_mode", 32'(mode), 0);
    chk("arst_chg", 32'(chg), 0);
    chk("arst_kind7", 32'(kind[7]), 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_edge_pf", 32'(pf), 2);
    slower = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
